// File: rtl/ac_motor_carrier_nch.sv
`default_nettype none
// ============================================================================
//  Module      : ac_motor_carrier_nch
//  Description : N-channel, phase-shifted, amplitude-scaled signed triangle
//                carrier generator for AC motor PWM comparators.
//                Includes a direction-reversal interlock with programmable
//                lockout, amplitude update synchronised to the phase wrap,
//                and a phase-tick prescaler.
//  Ports       : clk        - system clock, rising edge
//                rst_n      - asynchronous active-low reset
//                cw_in      - clockwise request
//                ccw_in     - counter-clockwise request
//                amplitude  - signed scale factor (AMP_W bits)
//                cw_out     - running clockwise
//                ccw_out    - running counter-clockwise
//                lock       - reversal lockout active
//                triangle   - CHANNELS packed signed carriers, WIDTH+AMP_W each
//  Revision    : 1.0 - initial release
// ============================================================================
module ac_motor_carrier_nch #(
    parameter int WIDTH       = 12,
    parameter int AMP_W       = 12,
    parameter int CHANNELS    = 3,
    parameter int DIV         = 1,
    parameter int LOCK_CYCLES = 1024
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               cw_in,
    input  logic                               ccw_in,
    input  logic signed [AMP_W-1:0]            amplitude,
    output logic                               cw_out,
    output logic                               ccw_out,
    output logic                               lock,
    output logic [CHANNELS*(WIDTH+AMP_W)-1:0]  triangle
);

    localparam int c_PHASE_W = WIDTH + 1;
    localparam int c_OUT_W   = WIDTH + AMP_W;
    localparam int c_PRE_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int c_LOCK_W  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    localparam logic [c_PRE_W-1:0]   c_PRE_LAST  = c_PRE_W'(DIV - 1);
    localparam logic [c_LOCK_W-1:0]  c_LOCK_LOAD = c_LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [c_PHASE_W-1:0] c_PHASE_MAX = {c_PHASE_W{1'b1}};
    localparam logic [c_PHASE_W-1:0] c_PHASE_ONE = c_PHASE_W'(1);

    localparam logic [1:0] c_ST_STOP    = 2'd0;
    localparam logic [1:0] c_ST_RUN_CW  = 2'd1;
    localparam logic [1:0] c_ST_RUN_CCW = 2'd2;
    localparam logic [1:0] c_ST_LOCK    = 2'd3;

    logic [1:0]                r_state;
    logic [1:0]                w_state_nxt;
    logic [c_LOCK_W-1:0]       r_lock_cnt;
    logic [c_PRE_W-1:0]        r_pre;
    logic [c_PHASE_W-1:0]      r_phase;
    logic signed [AMP_W-1:0]   r_amp;

    logic w_req_cw;
    logic w_req_ccw;
    logic w_running;
    logic w_running_nxt;
    logic w_tick;
    logic w_wrap;
    logic w_enter_lock;

    // Both requests high is treated as no request.
    assign w_req_cw  = cw_in & ~ccw_in;
    assign w_req_ccw = ccw_in & ~cw_in;

    assign w_running = (r_state == c_ST_RUN_CW) || (r_state == c_ST_RUN_CCW);
    assign w_tick    = w_running && (r_pre == c_PRE_LAST);

    // Amplitude may only change on the tick that wraps the phase, so every
    // carrier period is produced with a single scale factor.
    assign w_wrap = w_tick &&
                    (((r_state == c_ST_RUN_CW)  && (r_phase == c_PHASE_MAX)) ||
                     ((r_state == c_ST_RUN_CCW) && (r_phase == '0)));

    always_comb begin
        w_state_nxt  = r_state;
        w_enter_lock = 1'b0;
        case (r_state)
            c_ST_STOP: begin
                if (w_req_cw)
                    w_state_nxt = c_ST_RUN_CW;
                else if (w_req_ccw)
                    w_state_nxt = c_ST_RUN_CCW;
            end
            c_ST_RUN_CW: begin
                if (w_req_ccw) begin
                    w_state_nxt  = c_ST_LOCK;
                    w_enter_lock = 1'b1;
                end else if (!w_req_cw) begin
                    w_state_nxt = c_ST_STOP;
                end
            end
            c_ST_RUN_CCW: begin
                if (w_req_cw) begin
                    w_state_nxt  = c_ST_LOCK;
                    w_enter_lock = 1'b1;
                end else if (!w_req_ccw) begin
                    w_state_nxt = c_ST_STOP;
                end
            end
            default: begin
                // Exit direction is decided only when the count expires, so
                // request activity during the lockout cannot shorten it.
                if (r_lock_cnt == '0) begin
                    if (w_req_cw)
                        w_state_nxt = c_ST_RUN_CW;
                    else if (w_req_ccw)
                        w_state_nxt = c_ST_RUN_CCW;
                    else
                        w_state_nxt = c_ST_STOP;
                end
            end
        endcase
    end

    assign w_running_nxt = (w_state_nxt == c_ST_RUN_CW) || (w_state_nxt == c_ST_RUN_CCW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_STOP;
            r_lock_cnt <= '0;
            r_pre      <= '0;
            r_phase    <= '0;
            r_amp      <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_enter_lock)
                r_lock_cnt <= c_LOCK_LOAD;
            else if ((r_state == c_ST_LOCK) && (r_lock_cnt != '0))
                r_lock_cnt <= r_lock_cnt - c_LOCK_W'(1);

            if (!w_running || (r_pre == c_PRE_LAST))
                r_pre <= '0;
            else
                r_pre <= r_pre + c_PRE_W'(1);

            // Phase restarts from zero only in STOP; LOCK keeps it so the
            // reversed run continues from the same carrier position.
            if (r_state == c_ST_STOP)
                r_phase <= '0;
            else if (w_tick && (r_state == c_ST_RUN_CW))
                r_phase <= r_phase + c_PHASE_ONE;
            else if (w_tick && (r_state == c_ST_RUN_CCW))
                r_phase <= r_phase - c_PHASE_ONE;

            if ((r_state == c_ST_STOP) || w_wrap)
                r_amp <= amplitude;
        end
    end

    assign cw_out  = (r_state == c_ST_RUN_CW);
    assign ccw_out = (r_state == c_ST_RUN_CCW);
    assign lock    = (r_state == c_ST_LOCK);

    genvar k;
    generate
        for (k = 0; k < CHANNELS; k++) begin : g_ch
            localparam logic [c_PHASE_W-1:0] c_OFS =
                c_PHASE_W'(k * ((2 ** c_PHASE_W) / CHANNELS));

            logic [c_PHASE_W-1:0]      w_pk;
            logic [WIDTH-1:0]          w_fold;
            logic signed [WIDTH-1:0]   w_tri;
            logic signed [c_OUT_W-1:0] w_tri_x;
            logic signed [c_OUT_W-1:0] w_amp_x;
            logic signed [c_OUT_W-1:0] w_prod;
            logic signed [c_OUT_W-1:0] r_tri;

            assign w_pk = r_phase + c_OFS;

            // Falling half: (P-1-pk) equals the bitwise inverse of the low
            // WIDTH bits. Subtracting 2^(WIDTH-1) is an MSB inversion.
            assign w_fold = w_pk[WIDTH] ? ~w_pk[WIDTH-1:0] : w_pk[WIDTH-1:0];
            assign w_tri  = {~w_fold[WIDTH-1], w_fold[WIDTH-2:0]};

            assign w_tri_x = c_OUT_W'(w_tri);
            assign w_amp_x = c_OUT_W'(r_amp);
            assign w_prod  = w_tri_x * w_amp_x;

            // Output is zero unless the block is running now and keeps
            // running, so STOP and LOCK show zero from their first clock.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_tri <= '0;
                else if (w_running && w_running_nxt)
                    r_tri <= w_prod;
                else
                    r_tri <= '0;
            end

            assign triangle[k*c_OUT_W +: c_OUT_W] = r_tri;
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/ac_motor_carrier_nch.md
Name: ac_motor_carrier_nch

Overview:
- Parametrised N-channel successor to the single-channel AC motor triangle generator.
- Produces CHANNELS phase-shifted, amplitude-scaled signed triangle carriers for PWM/sine comparison stages.
- Adds a direction-reversal interlock with programmable lockout, glitch-free amplitude update and a tick prescaler.
- Sits between the direction command logic and the per-phase PWM comparators.

Parameters:
- WIDTH, 12, triangle magnitude width; triangle range is -2^(WIDTH-1)..2^(WIDTH-1)-1.
- AMP_W, 12, signed amplitude width; each output is WIDTH+AMP_W bits.
- CHANNELS, 3, number of carriers (1..8).
- DIV, 1, clocks per phase tick (>=1).
- LOCK_CYCLES, 1024, clocks of forced zero output on a direction reversal (>=1).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cw_in  in  1  clockwise request.
- ccw_in  in  1  counter-clockwise request.
- amplitude  in  AMP_W  signed scale factor.
- cw_out  out  1  running clockwise.
- ccw_out  out  1  running counter-clockwise.
- lock  out  1  reversal lockout active.
- triangle  out  CHANNELS*(WIDTH+AMP_W)  packed signed carriers; channel k occupies bits [(k+1)*(WIDTH+AMP_W)-1 : k*(WIDTH+AMP_W)].

Behaviour:
- Reset (async, rst_n=0):
  - State is STOP; phase=0; prescaler=0; amp_reg=0.
  - triangle=0, cw_out=0, ccw_out=0, lock=0.
- Request decode: req=CW if cw_in & ~ccw_in; req=CCW if ccw_in & ~cw_in; otherwise req=NONE. Both high counts as NONE.
- Prescaler: counts 0..DIV-1 only in RUN_CW/RUN_CCW. tick=1 when it equals DIV-1, then it wraps to 0. It is cleared in STOP and LOCK.
- Phase: unsigned WIDTH+1 bits, P=2^(WIDTH+1).
  - On tick: +1 mod P in RUN_CW, -1 mod P in RUN_CCW. Otherwise held.
  - Period is P*DIV clocks (8192 at defaults).
- Channel phase: pk = (phase + k*floor(P/CHANNELS)) mod P.
- Triangle: t = pk - 2^(WIDTH-1) if pk < 2^WIDTH, else (P-1-pk) - 2^(WIDTH-1).
  - pk=0 gives -2048; pk=4095 and pk=4096 give +2047; pk=8191 gives -2048 (defaults). There is no repeated sample at the turning points beyond this.
- Output: triangle_k = t_k * amp_reg, a full-precision signed product with no truncation or saturation.
  - Registered one clock after the phase register; latency is 1 clock.
  - Forced to 0 on the clock after entering STOP or LOCK.
- amp_reg:
  - Loads amplitude every clock in STOP.
  - While running, loads amplitude only on a tick where phase wraps (CW: 8191->0; CCW: 0->8191).
  - Held in LOCK.
- FSM, transitions on the clock edge:
  - STOP: req=CW -> RUN_CW; req=CCW -> RUN_CCW. Phase is reset to 0 in STOP.
  - RUN_CW: req=NONE -> STOP; req=CCW -> LOCK, with lock_cnt=LOCK_CYCLES-1. Otherwise stay.
  - RUN_CCW: symmetric to RUN_CW.
  - LOCK: lock_cnt decrements every clock. Phase is held, not reset. When lock_cnt=0, exit to RUN_CW, RUN_CCW or STOP according to req sampled that clock.
    - A request toggling back and forth during LOCK does not restart the count.
    - req=NONE during LOCK does not shorten the lockout.
- Flags are registered from state: cw_out=(state==RUN_CW), ccw_out=(state==RUN_CCW), lock=(state==LOCK). cw_out and ccw_out are never both 1.
- STOP -> RUN does not pass through LOCK. Only a direct reversal locks.
- rst_n asserted mid-run or mid-LOCK: everything clears immediately. Outputs are 0 until the next rising edge after release.

Test Plan:
- Reset, then cw_in=1, ccw_in=0, amplitude=1, DIV=1, CHANNELS=3: cw_out=1 after one clock. ch0 = -2048, -2047, ... reaches +2047 after 4095 ticks, returns to -2048 at 8192. ch1 leads ch0 by 2730 phase steps; ch2 by 5460.
- amplitude=3 while running, changed to -5 at mid-period: output stays 3*t until phase wraps 8191->0, then becomes -5*t. At peak t=2047 the product is -10235, width 24 exact.
- Running CW with phase=1000, switch to cw_in=0, ccw_in=1: lock=1 and all outputs 0 for exactly 1024 clocks. Then ccw_out=1 and phase resumes from 1000 downward (999, 998, ...).
- During LOCK toggle ccw_in/cw_in several times and end with both 0: lock lasts the full 1024 clocks, then STOP with phase=0 and outputs 0.
- cw_in=ccw_in=1 while running: STOP on the next clock with lock=0. With DIV=4, phase advances exactly once every 4 clocks while running.
- Assert rst_n=0 asynchronously mid-LOCK (not on a clock edge): all outputs 0 immediately. After release with cw_in=1, run starts from phase 0.
